motion_line_scheduler: RTL and testbench

- Per-scanline sequencer for the motion-object path of the sprite pixel ROM lookup block.
- On each line_start it scans every motion-object slot in motion RAM and tests each for vertical overlap with next_line.
- For each matching object it streams column lookups into the pixel ROM lookup block (1-cycle read latency) and writes non-transparent color codes into the line buffer at the object's horizontal position.
- Runs during horizontal blank and owns the motion-side lookup interface.

---
 rtl/motion_line_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_motion_line_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_line_scheduler.sv
// motion_line_scheduler
// Per-scanline sequencer for the motion-object path. On line_start it walks all
// motion RAM slots, tests each for vertical overlap with next_line, streams the
// column lookups of every matching object into the pixel ROM lookup block, and
// writes the non-transparent color codes it gets back into the line buffer.
//
// Ports
//   clk, rst_l             clock, asynchronous active-low reset
//   line_start, next_line  start pulse and the scanline to prepare
//   mo_addr                motion RAM slot address (data returns one cycle later)
//   mo_pic/vpos/hpos/wide  motion RAM read data
//   spriteID, tileRow,
//   tileCol, motionSelect,
//   motionWide             lookup request to the pixel ROM block
//   colorCode              lookup response, one cycle after the request
//   lb_we, lb_addr, lb_data line-buffer write port
//   busy, done             scan in progress / one-cycle completion pulse
module motion_line_scheduler #(
    parameter int unsigned NUM_OBJ    = 16,
    parameter int unsigned LINE_WIDTH = 240,
    parameter int unsigned OBJ_HEIGHT = 8
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       line_start,
    input  logic [7:0]                 next_line,
    output logic [$clog2(NUM_OBJ)-1:0] mo_addr,
    input  logic [7:0]                 mo_pic,
    input  logic [7:0]                 mo_vpos,
    input  logic [7:0]                 mo_hpos,
    input  logic                       mo_wide,
    output logic [7:0]                 spriteID,
    output logic [2:0]                 tileRow,
    output logic [2:0]                 tileCol,
    output logic                       motionSelect,
    output logic                       motionWide,
    input  logic [1:0]                 colorCode,
    output logic                       lb_we,
    output logic [7:0]                 lb_addr,
    output logic [1:0]                 lb_data,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SLOT_W = $clog2(NUM_OBJ);
    localparam logic [8:0]  LW     = 9'(LINE_WIDTH);
    localparam logic [7:0]  OBJ_H  = 8'(OBJ_HEIGHT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]        line_q, line_d;
    logic [7:0]        hpos_q, hpos_d;
    logic [3:0]        col_q, col_d;
    logic [3:0]        last_col_q, last_col_d;
    logic [7:0]        x_pipe_q, x_pipe_d;
    logic              pv_q, pv_d;

    logic [SLOT_W-1:0] mo_addr_d;
    logic [7:0]        sprite_d;
    logic [2:0]        row_d, tcol_d;
    logic              msel_d, mwide_d, busy_d, done_d;

    logic [7:0]        row_c;
    logic [3:0]        next_col_c;
    logic              last_slot_c;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            line_q       <= '0;
            hpos_q       <= '0;
            col_q        <= '0;
            last_col_q   <= '0;
            x_pipe_q     <= '0;
            pv_q         <= 1'b0;
            mo_addr      <= '0;
            spriteID     <= '0;
            tileRow      <= '0;
            tileCol      <= '0;
            motionSelect <= 1'b0;
            motionWide   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            line_q       <= line_d;
            hpos_q       <= hpos_d;
            col_q        <= col_d;
            last_col_q   <= last_col_d;
            x_pipe_q     <= x_pipe_d;
            pv_q         <= pv_d;
            mo_addr      <= mo_addr_d;
            spriteID     <= sprite_d;
            tileRow      <= row_d;
            tileCol      <= tcol_d;
            motionSelect <= msel_d;
            motionWide   <= mwide_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        line_d      = line_q;
        hpos_d      = hpos_q;
        col_d       = col_q;
        last_col_d  = last_col_q;
        x_pipe_d    = x_pipe_q;
        pv_d        = 1'b0;
        mo_addr_d   = mo_addr;
        sprite_d    = spriteID;
        row_d       = tileRow;
        tcol_d      = tileCol;
        msel_d      = 1'b0;
        mwide_d     = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;
        row_c       = line_q - mo_vpos;
        next_col_c  = col_q + 4'd1;
        last_slot_c = (slot_q == SLOT_W'(NUM_OBJ - 1));

        // The x of the request on the bus this cycle pairs with next cycle's colorCode
        if (state_q == S_FETCH) begin
            x_pipe_d = hpos_q + 8'(col_q);
            pv_d     = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    line_d    = next_line;
                    slot_d    = '0;
                    mo_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Wrapped subtraction: objects below the line give a large row
                if (row_c < OBJ_H) begin
                    sprite_d   = mo_pic;
                    row_d      = row_c[2:0];
                    hpos_d     = mo_hpos;
                    col_d      = 4'd0;
                    last_col_d = mo_wide ? 4'd15 : 4'd7;
                    tcol_d     = 3'd0;
                    msel_d     = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    done_d  = last_slot_c;
                    state_d = S_NEXT;
                end
            end
            S_FETCH: begin
                if (col_q == last_col_q) begin
                    state_d = S_DRAIN;
                end else begin
                    col_d   = next_col_c;
                    tcol_d  = next_col_c[2:0];
                    mwide_d = next_col_c[3];
                    msel_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                done_d  = last_slot_c;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_slot_c) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    slot_d    = slot_q + SLOT_W'(1);
                    mo_addr_d = slot_q + SLOT_W'(1);
                    state_d   = S_READ;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A new line_start mid-scan restarts from slot 0 and drops the in-flight write
        if (line_start && (state_q != S_IDLE)) begin
            line_d    = next_line;
            slot_d    = '0;
            mo_addr_d = '0;
            busy_d    = 1'b1;
            msel_d    = 1'b0;
            mwide_d   = 1'b0;
            pv_d      = 1'b0;
            done_d    = 1'b0;
            state_d   = S_READ;
        end
    end

    // Line-buffer write port: pipe registers plus the returning color code
    assign lb_we   = pv_q && (colorCode != 2'b00) && ({1'b0, x_pipe_q} < LW);
    assign lb_addr = x_pipe_q;
    assign lb_data = pv_q ? colorCode : 2'b00;

endmodule

// File: tb/tb_motion_line_scheduler.sv
// Testbench for motion_line_scheduler: motion RAM and pixel ROM models, a
// line-buffer model, and a scoreboard of expected lookups and writes.
module tb_motion_line_scheduler;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       line_start;
    logic [7:0] next_line;
    logic [3:0] mo_addr;
    logic [7:0] mo_pic, mo_vpos, mo_hpos;
    logic       mo_wide;
    logic [7:0] spriteID;
    logic [2:0] tileRow, tileCol;
    logic       motionSelect, motionWide;
    logic [1:0] colorCode;
    logic       lb_we;
    logic [7:0] lb_addr;
    logic [1:0] lb_data;
    logic       busy, done;

    logic [7:0] ram_pic  [16];
    logic [7:0] ram_vpos [16];
    logic [7:0] ram_hpos [16];
    logic       ram_wide [16];
    logic [1:0] rom      [256];
    logic [1:0] lb_mem   [256];
    logic       lb_clr;

    logic [14:0] req_q [$];
    logic [9:0]  wr_q  [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    motion_line_scheduler #(.NUM_OBJ(16), .LINE_WIDTH(240), .OBJ_HEIGHT(8)) dut (
        .clk(clk), .rst_l(rst_l), .line_start(line_start), .next_line(next_line),
        .mo_addr(mo_addr), .mo_pic(mo_pic), .mo_vpos(mo_vpos), .mo_hpos(mo_hpos),
        .mo_wide(mo_wide), .spriteID(spriteID), .tileRow(tileRow), .tileCol(tileCol),
        .motionSelect(motionSelect), .motionWide(motionWide), .colorCode(colorCode),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data), .busy(busy), .done(done)
    );

    // Motion RAM: registered read, one cycle latency
    always @(posedge clk) begin
        mo_pic  <= ram_pic[mo_addr];
        mo_vpos <= ram_vpos[mo_addr];
        mo_hpos <= ram_hpos[mo_addr];
        mo_wide <= ram_wide[mo_addr];
    end

    // Pixel ROM: code depends on sprite, wide half and column
    always @(posedge clk)
        colorCode <= motionSelect ? rom[{spriteID[3:0], motionWide, tileCol}] : 2'b00;

    // Line buffer
    always @(posedge clk) begin
        if (lb_clr) begin
            for (int i = 0; i < 256; i++) lb_mem[i] <= 2'b00;
        end else if (lb_we) begin
            lb_mem[lb_addr] <= lb_data;
        end
    end

    task automatic ram_default();
        for (int s = 0; s < 16; s++) begin
            ram_pic[s]  = 8'(s);
            ram_vpos[s] = 8'hF0;
            ram_hpos[s] = 8'h00;
            ram_wide[s] = 1'b0;
        end
    endtask

    task automatic rom_fill(input logic [3:0] pic, input logic [1:0] code);
        for (int i = 0; i < 16; i++) rom[{pic, 4'(i)}] = code;
    endtask

    task automatic clear_lb();
        @(negedge clk);
        lb_clr = 1'b1;
        @(posedge clk);
        #1 lb_clr = 1'b0;
    endtask

    // Expected lookups and writes for a full scan of the given line
    task automatic build_expect(input logic [7:0] line);
        logic [7:0] row, x;
        logic [3:0] c4;
        logic [1:0] code;
        int         n;
        req_q.delete();
        wr_q.delete();
        for (int s = 0; s < 16; s++) begin
            row = line - ram_vpos[s];
            if (row < 8'd8) begin
                n = ram_wide[s] ? 16 : 8;
                for (int c = 0; c < n; c++) begin
                    c4   = 4'(c);
                    x    = ram_hpos[s] + 8'(c);
                    code = rom[{ram_pic[s][3:0], c4[3], c4[2:0]}];
                    req_q.push_back({ram_pic[s], row[2:0], c4[2:0], c4[3]});
                    if (code != 2'b00 && x < 8'd240) wr_q.push_back({x, code});
                end
            end
        end
    endtask

    task automatic start_line(input logic [7:0] line);
        next_line  = line;
        line_start = 1'b1;
        @(posedge clk);
        #1 line_start = 1'b0;
    endtask

    // Runs until the cycle after done, scoring every request and write
    task automatic run_scan(input string name, output int done_cyc, output int n_req,
                            output int n_wr);
        int       cyc;
        bit       fin, busy_bad;
        logic [14:0] r;
        logic [9:0]  w;
        cyc = 0; fin = 0; busy_bad = 0; done_cyc = -1; n_req = 0; n_wr = 0;
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (motionSelect) begin
                n_req++;
                n_checks++;
                if (req_q.size() == 0) begin
                    $display("FAIL %s req: unexpected request %h", name,
                             {spriteID, tileRow, tileCol, motionWide});
                end else begin
                    r = req_q.pop_front();
                    if ({spriteID, tileRow, tileCol, motionWide} !== r)
                        $display("FAIL %s req: got %h want %h", name,
                                 {spriteID, tileRow, tileCol, motionWide}, r);
                    else n_pass++;
                end
            end
            if (lb_we) begin
                n_wr++;
                n_checks++;
                if (wr_q.size() == 0) begin
                    $display("FAIL %s write: unexpected x=%h data=%h", name, lb_addr, lb_data);
                end else begin
                    w = wr_q.pop_front();
                    if ({lb_addr, lb_data} !== w)
                        $display("FAIL %s write: got x=%h data=%h want x=%h data=%h", name,
                                 lb_addr, lb_data, w[9:2], w[1:0]);
                    else n_pass++;
                end
            end
            if (done_cyc >= 0) begin
                n_checks++;
                if (busy !== 1'b0 || done !== 1'b0)
                    $display("FAIL %s end: busy=%b done=%b want 0 0", name, busy, done);
                else n_pass++;
                fin = 1;
            end else begin
                if (busy !== 1'b1) busy_bad = 1;
                if (done === 1'b1) done_cyc = cyc;
            end
        end
        n_checks++;
        if (!fin) $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        else n_pass++;
        n_checks++;
        if (busy_bad) $display("FAIL %s busy: busy low before done, want high", name);
        else n_pass++;
        n_checks++;
        if (req_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL %s leftover: req=%0d wr=%0d want 0 0", name, req_q.size(), wr_q.size());
        else n_pass++;
    endtask

    task automatic wait_fetch(input int slot, output bit ok, output int n_done);
        ok = 0; n_done = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (motionSelect === 1'b1 && mo_addr == 4'(slot)) ok = 1;
        end
        n_checks++;
        if (!ok) $display("FAIL wait_fetch: slot %0d never fetched, got none want fetch", slot);
        else n_pass++;
    endtask

    task automatic check_zero(input string name);
        logic [35:0] all;
        all = {mo_addr, spriteID, tileRow, tileCol, motionSelect, motionWide,
               lb_we, lb_addr, lb_data, busy, done};
        n_checks++;
        if (all !== 36'd0) $display("FAIL %s: outputs %h want 0", name, all);
        else n_pass++;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %0d want %0d", name, got, want);
        else n_pass++;
    endtask

    task automatic setup_narrow();
        ram_default();
        ram_pic[3] = 8'h05; ram_vpos[3] = 8'h20; ram_hpos[3] = 8'h40; ram_wide[3] = 1'b0;
        rom[8'h50] = 2'd1; rom[8'h51] = 2'd0; rom[8'h52] = 2'd2; rom[8'h53] = 2'd3;
        rom[8'h54] = 2'd1; rom[8'h55] = 2'd1; rom[8'h56] = 2'd0; rom[8'h57] = 2'd2;
    endtask

    task automatic test_reset();
        bit ok;
        int nd, dc, nr, nw;
        rst_l = 1'b0;
        #12;
        check_zero("reset_state");
        @(negedge clk);
        rst_l = 1'b1;
        setup_narrow();
        @(negedge clk);
        start_line(8'h23);
        wait_fetch(3, ok, nd);
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        check_zero("reset_mid_fetch");
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        build_expect(8'h23);
        start_line(8'h23);
        run_scan("post_reset", dc, nr, nw);
        check_int("post_reset done_cyc", dc, 57);
        check_int("post_reset writes", nw, 6);
    endtask

    task automatic test_no_match();
        int dc, nr, nw;
        ram_default();
        build_expect(8'h10);
        @(negedge clk);
        start_line(8'h10);
        run_scan("no_match", dc, nr, nw);
        check_int("no_match done_cyc", dc, 48);
        check_int("no_match writes", nw, 0);
    endtask

    task automatic test_narrow();
        int dc, nr, nw;
        logic [1:0] exp_lb [8];
        exp_lb = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2};
        setup_narrow();
        clear_lb();
        build_expect(8'h23);
        @(negedge clk);
        start_line(8'h23);
        run_scan("narrow", dc, nr, nw);
        check_int("narrow requests", nr, 8);
        check_int("narrow writes", nw, 6);
        check_int("narrow done_cyc", dc, 57);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (lb_mem[8'h40 + 8'(i)] !== exp_lb[i])
                $display("FAIL narrow lb[%h]: got %0d want %0d", 8'h40 + 8'(i),
                         lb_mem[8'h40 + 8'(i)], exp_lb[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wide_clip();
        int dc, nr, nw;
        ram_default();
        ram_pic[0] = 8'h0A; ram_vpos[0] = 8'h50; ram_hpos[0] = 8'hEC; ram_wide[0] = 1'b1;
        rom_fill(4'hA, 2'd1);
        clear_lb();
        build_expect(8'h50);
        @(negedge clk);
        start_line(8'h50);
        run_scan("wide_clip", dc, nr, nw);
        check_int("wide_clip requests", nr, 16);
        check_int("wide_clip writes", nw, 4);
        check_int("wide_clip done_cyc", dc, 65);
        check_int("wide_clip lb[EF]", int'(lb_mem[8'hEF]), 1);
        check_int("wide_clip lb[00]", int'(lb_mem[8'h00]), 0);
    endtask

    task automatic test_wrap();
        int dc, nr, nw;
        ram_default();
        ram_pic[7] = 8'h0C; ram_vpos[7] = 8'hFC; ram_hpos[7] = 8'hFC; ram_wide[7] = 1'b1;
        ram_vpos[8] = 8'h03;
        rom_fill(4'hC, 2'd2);
        clear_lb();
        build_expect(8'h02);
        @(negedge clk);
        start_line(8'h02);
        run_scan("wrap", dc, nr, nw);
        check_int("wrap requests", nr, 16);
        check_int("wrap writes", nw, 12);
        check_int("wrap lb[00]", int'(lb_mem[8'h00]), 2);
        check_int("wrap lb[0B]", int'(lb_mem[8'h0B]), 2);
        check_int("wrap lb[0C]", int'(lb_mem[8'h0C]), 0);
    endtask

    task automatic test_priority();
        int dc, nr, nw;
        ram_default();
        ram_pic[2] = 8'h02; ram_vpos[2] = 8'h00; ram_hpos[2] = 8'h10;
        ram_pic[9] = 8'h09; ram_vpos[9] = 8'h00; ram_hpos[9] = 8'h10;
        rom_fill(4'h2, 2'd2);
        rom_fill(4'h9, 2'd3);
        clear_lb();
        build_expect(8'h00);
        @(negedge clk);
        start_line(8'h00);
        run_scan("priority", dc, nr, nw);
        check_int("priority writes", nw, 16);
        check_int("priority done_cyc", dc, 66);
        check_int("priority lb[10]", int'(lb_mem[8'h10]), 3);
        check_int("priority lb[17]", int'(lb_mem[8'h17]), 3);
    endtask

    task automatic test_abort();
        bit ok;
        int nd, dc, nr, nw;
        ram_default();
        ram_pic[5] = 8'h07; ram_vpos[5] = 8'h30; ram_hpos[5] = 8'h80;
        rom_fill(4'h7, 2'd3);
        @(negedge clk);
        start_line(8'h35);
        wait_fetch(5, ok, nd);
        build_expect(8'h30);
        start_line(8'h30);
        n_checks++;
        if (mo_addr !== 4'd0 || motionSelect !== 1'b0 || lb_we !== 1'b0 || busy !== 1'b1)
            $display("FAIL abort restart: mo_addr=%h sel=%b we=%b busy=%b want 0 0 0 1",
                     mo_addr, motionSelect, lb_we, busy);
        else n_pass++;
        run_scan("abort", dc, nr, nw);
        check_int("abort done total", nd + ((dc >= 0) ? 1 : 0), 1);
        check_int("abort done_cyc", dc, 57);
        check_int("abort requests", nr, 8);
    endtask

    initial begin
        line_start = 1'b0;
        next_line  = 8'h00;
        lb_clr     = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 2'($urandom_range(0, 3));
        ram_default();
        test_reset();
        test_no_match();
        test_narrow();
        test_wide_clip();
        test_wrap();
        test_priority();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

endmodule
